// File: rtl/pdm_cic_pkg.sv
// Shared constants and helpers for the PDM CIC decimator:
// widths, ratio_sel codes, per-code terminal count and output shift.
package pdm_cic_pkg;

  localparam int ACC_W = 13;
  localparam int OUT_W = 6;
  localparam int CNT_W = 6;

  localparam logic [1:0] RATIO_8  = 2'b00;
  localparam logic [1:0] RATIO_16 = 2'b01;
  localparam logic [1:0] RATIO_32 = 2'b10;
  localparam logic [1:0] RATIO_64 = 2'b11;

  localparam logic [1:0] WARM_DONE = 2'd2;

  // R-1 for a ratio code
  function automatic logic [CNT_W-1:0] ratio_last(
    input logic [1:0] sel
  );
    logic [CNT_W-1:0] v;
    v = '0;
    unique case (sel)
      RATIO_8:  v = 6'd7;
      RATIO_16: v = 6'd15;
      RATIO_32: v = 6'd31;
      RATIO_64: v = 6'd63;
    endcase
    return v;
  endfunction

  // 2*log2(R) - out_w : CIC gain is R^2
  function automatic logic [3:0] out_shift(
    input logic [1:0] sel,
    input int         out_w
  );
    int s;
    s = 2 * (3 + int'(sel)) - out_w;
    return 4'(s);
  endfunction

endpackage

// File: rtl/pdm_cic_integrator.sv
// Two cascaded modular integrators of the CIC decimator.
// Ports: clk, reset, i_enable (hold when 0), i_flush (sync clear),
// i_pdm (1-bit sample), o_i2 (second integrator).
module pdm_cic_integrator #(
  parameter int ACC_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_flush,
  input  logic             i_pdm,
  output logic [ACC_W-1:0] o_i2
);

  logic [ACC_W-1:0] r_i1;
  logic [ACC_W-1:0] r_i2;

  // i2 accumulates the pre-edge i1; wrap is harmless
  // because the comb differences undo it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i1 <= '0;
      r_i2 <= '0;
    end else if (i_flush) begin
      r_i1 <= '0;
      r_i2 <= '0;
    end else if (i_enable) begin
      r_i1 <= r_i1 + ACC_W'(i_pdm);
      r_i2 <= r_i2 + r_i1;
    end
  end

  assign o_i2 = r_i2;

endmodule

// File: rtl/pdm_cic_decimator.sv
// Second-order CIC decimator for a 1-bit PDM stream, R = 8..64.
// Ports: clk, reset, pdm_in, enable, ratio_sel, pcm_out, pcm_valid.
module pdm_cic_decimator #(
  parameter int ACC_W = pdm_cic_pkg::ACC_W,
  parameter int OUT_W = pdm_cic_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pdm_in,
  input  logic             enable,
  input  logic [1:0]       ratio_sel,
  output logic [OUT_W-1:0] pcm_out,
  output logic             pcm_valid
);

  import pdm_cic_pkg::*;

  logic [1:0]       r_ratio;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_samp;
  logic [ACC_W-1:0] r_samp_z;
  logic [ACC_W-1:0] r_c1_z;
  logic             r_go;
  logic [1:0]       r_warm;
  logic [OUT_W-1:0] r_pcm;
  logic             r_valid;

  logic             w_flush;
  logic [CNT_W-1:0] w_last;
  logic             w_tick;
  logic [ACC_W-1:0] w_i2;
  logic [ACC_W-1:0] w_c1;
  logic [ACC_W-1:0] w_c2;
  logic [3:0]       w_shift;
  logic [ACC_W-1:0] w_shifted;
  logic             w_sat;
  logic [OUT_W-1:0] w_pcm;

  // a ratio change restarts the whole filter
  assign w_flush = (ratio_sel != r_ratio);
  assign w_last  = ratio_last(r_ratio);
  assign w_tick  = enable & (r_cnt == w_last) & ~w_flush;

  pdm_cic_integrator #(
    .ACC_W (ACC_W)
  ) u_integ (
    .clk      (clk),
    .reset    (reset),
    .i_enable (enable),
    .i_flush  (w_flush),
    .i_pdm    (pdm_in),
    .o_i2     (w_i2)
  );

  assign w_c1 = r_samp - r_samp_z;
  assign w_c2 = w_c1 - r_c1_z;

  // anything left above OUT_W after the shift
  // means c2 >= R^2 (only the all-ones case)
  assign w_shift   = out_shift(r_ratio, OUT_W);
  assign w_shifted = w_c2 >> w_shift;
  assign w_sat     = |w_shifted[ACC_W-1:OUT_W];
  assign w_pcm     = w_sat ? '1 : w_shifted[OUT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ratio  <= RATIO_8;
      r_cnt    <= '0;
      r_samp   <= '0;
      r_samp_z <= '0;
      r_c1_z   <= '0;
      r_go     <= 1'b0;
      r_warm   <= '0;
      r_pcm    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_flush) begin
        r_ratio  <= ratio_sel;
        r_cnt    <= '0;
        r_samp   <= '0;
        r_samp_z <= '0;
        r_c1_z   <= '0;
        r_go     <= 1'b0;
        r_warm   <= '0;
      end else begin
        if (enable) begin
          if (r_cnt == w_last) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        r_go <= w_tick;
        if (w_tick) begin
          r_samp <= w_i2;
        end
        // comb runs the cycle after a tick,
        // whatever enable does then
        if (r_go) begin
          r_samp_z <= r_samp;
          r_c1_z   <= w_c1;
          if (r_warm == WARM_DONE) begin
            r_pcm   <= w_pcm;
            r_valid <= 1'b1;
          end else begin
            r_warm <= r_warm + 2'd1;
          end
        end
      end
    end
  end

  assign pcm_out   = r_pcm;
  assign pcm_valid = r_valid;

endmodule

// File: doc/pdm_cic_decimator.md
PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

Interface
REQ-001 Parameter ACC_W, default 13: integrator and comb width in bits (2*log2(64)+1).
REQ-002 Parameter OUT_W, default 6: PCM output width in bits.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 pdm_in  input  1  1-bit PDM stream, one sample per enabled clock; 1 weighs +1, 0 weighs 0.
REQ-006 enable  input  1  sample qualifier; when 0, the integrators and the decimation counter hold.
REQ-007 ratio_sel  input  2  decimation ratio R: 00=8, 01=16, 10=32, 11=64.
REQ-008 pcm_out  output  OUT_W  decimated, scaled PCM sample; holds its value between updates.
REQ-009 pcm_valid  output  1  single-cycle strobe marking a new pcm_out value.

Function
REQ-010 Two cascaded integrators SHALL update on every enable=1 cycle: i1 <= i1 + pdm_in and i2 <= i2 + i1 (using the pre-edge i1), both modulo 2^ACC_W.
REQ-011 A decimation counter cnt SHALL increment on every enable=1 cycle and wrap from R-1 to 0; a tick cycle is any cycle with enable=1 and cnt=R-1.
REQ-012 At the edge ending tick cycle T, the block SHALL capture samp <= i2 (pre-edge value) and set an internal comb-go flag.
REQ-013 At the edge ending cycle T+1, two comb stages SHALL compute c1 = samp - samp_z and c2 = c1 - c1_z, both modulo 2^ACC_W, then update samp_z <= samp and c1_z <= c1.
REQ-014 The comb stage SHALL complete independently of the enable value in cycle T+1.
REQ-015 Scaling: pcm_out SHALL equal c2 >> (2*log2(R) - OUT_W), which is a shift of 0, 2, 4 or 6 for R = 8, 16, 32 or 64.
REQ-016 Saturation: when c2 >= 2^(2*log2(R)), pcm_out SHALL be 2^OUT_W - 1; for example, all-ones input gives 63.
REQ-017 pcm_out and pcm_valid SHALL be registered at the edge ending T+1, so pcm_valid is high for exactly cycle T+2.
REQ-018 Warm-up: a 2-bit warm counter SHALL suppress pcm_valid, and leave pcm_out unchanged, for the first 2 comb results after reset or flush.
REQ-019 Register ratio_reg SHALL hold the active ratio; whenever ratio_sel differs from ratio_reg, a flush SHALL occur.
REQ-020 On that flush edge, the block SHALL load ratio_reg, zero i1, i2, cnt, samp, samp_z, c1_z, the comb-go flag and the warm counter, and leave pcm_out unchanged.
REQ-021 If a flush coincides with a tick cycle, the flush SHALL win and no sample is captured.
REQ-022 If a flush coincides with cycle T+1, the flush SHALL win and pcm_valid stays 0.
REQ-023 When enable=0, the block SHALL make no tick; a pending comb/output stage still completes.
REQ-024 The block SHALL have no backpressure; pcm_valid may not be stalled by any input.

Reset
REQ-025 reset=1 SHALL asynchronously clear i1, i2, cnt, samp, samp_z, c1_z, the comb-go flag, the warm counter and pcm_out to 0, set pcm_valid to 0, and set ratio_reg to 00.
REQ-026 A reset asserted mid-window or during cycle T+1 SHALL drop pcm_valid immediately and discard the partial window.
REQ-027 After reset release, the first pcm_valid SHALL occur no earlier than the third tick (third comb result).

Structure
REQ-028 Shared package pdm_cic_pkg SHALL hold ACC_W, OUT_W, the ratio_sel encoding, and functions giving R-1 and the output shift per ratio code.
REQ-029 The integrator pair (i1, i2, modular add, enable hold, flush clear) SHALL be one sub-module, pdm_cic_integrator; the counter, comb, scaler and control SHALL stay in the top module.
REQ-030 The block SHALL contain no multipliers; scaling SHALL be by shift mux only.

Verification
REQ-031 Reset, ratio_sel=00, enable=1, pdm_in=1 constant -> no pcm_valid for the first 2 ticks, then pcm_valid every 8 cycles with pcm_out=63 (saturated).
REQ-032 ratio_sel=00, pdm_in alternating 1/0 -> steady-state pcm_out=32; repeat with ratio_sel=11 -> pcm_out=32 with pcm_valid every 64 cycles.
REQ-033 Drive pdm_in from a bit-exact model of the team's 5-bit first-order PDM modulator with input k=16, ratio_sel=10 -> steady pcm_out=2k=32; repeat for k=0 -> 0 and k=31 -> 62.
REQ-034 ratio_sel changed 01->10 on a tick cycle -> flush on that edge, no pcm_valid from the old window, then the warm-up repeats and the period becomes 32.
REQ-035 enable toggled 1/0 every cycle with pdm_in=1, ratio_sel=00 -> pcm_valid every 16 clocks, pcm_out=63, integrators frozen on enable=0 cycles.
REQ-036 reset pulsed during cycle T+1 -> pcm_valid never asserts for that sample, all state is 0, and warm-up restarts.
